// File: rtl/fifo_ctrl_pkg.sv
// Shared widths, write-port payload type and configuration helpers for the
// ATA/IDE data-path FIFO controller.
//   FIFO_ADDR_WIDTH : dp_ram address width (AW)
//   FIFO_DATA_WIDTH : data word width (DW)
//   FIFO_DEPTH      : number of entries, must equal 2**AW
package fifo_ctrl_pkg;

  localparam int unsigned FIFO_ADDR_WIDTH = 4;
  localparam int unsigned FIFO_DATA_WIDTH = 16;
  localparam int unsigned FIFO_DEPTH      = 16;

  // Pointer width: one extra bit so full and empty are distinguishable.
  localparam int unsigned FIFO_PTR_WIDTH  = FIFO_ADDR_WIDTH + 1;

  // Registered payload presented to dp_ram port 0 (write port).
  typedef struct packed {
    logic [FIFO_ADDR_WIDTH-1:0] addr;
    logic [FIFO_DATA_WIDTH-1:0] data;
    logic                       cs;
    logic                       we;
  } ram_wr_t;

  // True when the entry count matches the address space exactly.
  function automatic bit depth_ok(input int unsigned aw, input int unsigned depth);
    return depth == (32'd1 << aw);
  endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Bus bundle between the FIFO controller, its producer/consumer and dp_ram.
//   master : producer/consumer side plus dp_ram read data (drives requests)
//   slave  : fifo_ctrl (drives flags, pop data and RAM strobes)
// Signals:
//   flush, wr_en, wr_data, rd_en       requests into the controller
//   full, empty, count, ovf, unf       status
//   rd_data, rd_valid                  registered pop data
//   ram_*_0                            dp_ram write port (port 0)
//   ram_*_1                            dp_ram read port (port 1)
interface fifo_ctrl_if;
  import fifo_ctrl_pkg::*;

  logic                       flush;
  logic                       wr_en;
  logic [FIFO_DATA_WIDTH-1:0] wr_data;
  logic                       full;
  logic                       rd_en;
  logic [FIFO_DATA_WIDTH-1:0] rd_data;
  logic                       rd_valid;
  logic                       empty;
  logic [FIFO_ADDR_WIDTH:0]   count;
  logic                       ovf;
  logic                       unf;

  logic [FIFO_ADDR_WIDTH-1:0] ram_addr_0;
  logic [FIFO_DATA_WIDTH-1:0] ram_data_0;
  logic                       ram_cs_0;
  logic                       ram_we_0;
  logic                       ram_oe_0;

  logic [FIFO_ADDR_WIDTH-1:0] ram_addr_1;
  logic [FIFO_DATA_WIDTH-1:0] ram_data_1;
  logic                       ram_cs_1;
  logic                       ram_we_1;
  logic                       ram_oe_1;

  modport master (
    output flush, wr_en, wr_data, rd_en, ram_data_1,
    input  full, rd_data, rd_valid, empty, count, ovf, unf,
    input  ram_addr_0, ram_data_0, ram_cs_0, ram_we_0, ram_oe_0,
    input  ram_addr_1, ram_cs_1, ram_we_1, ram_oe_1
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en, ram_data_1,
    output full, rd_data, rd_valid, empty, count, ovf, unf,
    output ram_addr_0, ram_data_0, ram_cs_0, ram_we_0, ram_oe_0,
    output ram_addr_1, ram_cs_1, ram_we_1, ram_oe_1
  );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer with synchronous clear and increment.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : advance by one, natural modulo 2**W wrap
//   ptr_q      : registered pointer
//   ptr_d_c    : combinational next value (lets the parent register flags
//                in the same cycle the pointer moves)
module fifo_ptr #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr_q,
  output logic [W-1:0] ptr_d_c
);

  // Next-pointer selection.
  always_comb begin
    ptr_d_c = ptr_q;
    if (clr) begin
      ptr_d_c = '0;
    end else if (inc) begin
      ptr_d_c = ptr_q + W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d_c;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for the dp_ram FIFO on the ATA/IDE data path.
// Turns push/pop handshakes into dp_ram port strobes (port 0 writes,
// port 1 reads) and provides full/empty/count, registered pop data and
// sticky overflow/underflow flags.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fifo_ctrl_if.slave (requests, status, dp_ram ports 0 and 1)
module fifo_ctrl
  import fifo_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  fifo_ctrl_if.slave  bus
);

  localparam int unsigned AW    = FIFO_ADDR_WIDTH;
  localparam int unsigned DW    = FIFO_DATA_WIDTH;
  localparam int unsigned DEPTH = FIFO_DEPTH;
  localparam int unsigned PW    = FIFO_PTR_WIDTH;

  // Configuration guard: pointer arithmetic assumes DEPTH fills the address space.
  if (!depth_ok(AW, DEPTH)) begin : g_bad_depth
    $error("fifo_ctrl: FIFO_DEPTH must equal 2**FIFO_ADDR_WIDTH");
  end

  logic          push_ok_c;
  logic          pop_ok_c;
  logic          ptr_clr;
  logic          wr_inc;
  logic          cmt_inc;
  logic          rd_inc;

  logic [PW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PW-1:0] cmt_ptr_q, cmt_ptr_d;
  logic [PW-1:0] rd_ptr_q,  rd_ptr_d;

  ram_wr_t       wr_port_q, wr_port_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          full_q,  full_d;
  logic          empty_q, empty_d;
  logic [PW-1:0] count_q, count_d;
  logic          ovf_q,   ovf_d;
  logic          unf_q,   unf_d;

  // Allocated (write) pointer: advances on every accepted push.
  fifo_ptr #(.W(PW)) u_wr_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (ptr_clr),
    .inc     (wr_inc),
    .ptr_q   (wr_ptr_q),
    .ptr_d_c (wr_ptr_d)
  );

  // Committed pointer: trails the write pointer by the one-cycle RAM write.
  fifo_ptr #(.W(PW)) u_cmt_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (ptr_clr),
    .inc     (cmt_inc),
    .ptr_q   (cmt_ptr_q),
    .ptr_d_c (cmt_ptr_d)
  );

  // Read pointer: advances on every accepted pop.
  fifo_ptr #(.W(PW)) u_rd_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (ptr_clr),
    .inc     (rd_inc),
    .ptr_q   (rd_ptr_q),
    .ptr_d_c (rd_ptr_d)
  );

  // Handshake decode, next-state for strobes/data/flags.
  always_comb begin
    ptr_clr      = bus.flush;
    push_ok_c    = bus.wr_en && !full_q;
    pop_ok_c     = bus.rd_en && !empty_q;

    wr_inc       = push_ok_c;
    rd_inc       = pop_ok_c;
    // A strobe issued last edge lands in the RAM at this edge, so commit it.
    cmt_inc      = wr_port_q.we;

    wr_port_d    = wr_port_q;
    wr_port_d.cs = 1'b0;
    wr_port_d.we = 1'b0;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    ovf_d        = ovf_q;
    unf_d        = unf_q;

    if (bus.flush) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (push_ok_c) begin
        wr_port_d.addr = wr_ptr_q[AW-1:0];
        wr_port_d.data = bus.wr_data;
        wr_port_d.cs   = 1'b1;
        wr_port_d.we   = 1'b1;
      end
      if (pop_ok_c) begin
        rd_data_d  = bus.ram_data_1;
        rd_valid_d = 1'b1;
      end
      if (bus.wr_en && full_q) begin
        ovf_d = 1'b1;
      end
      if (bus.rd_en && empty_q) begin
        unf_d = 1'b1;
      end
    end

    // Flags track the post-edge pointers so they stay aligned with them.
    full_d  = (wr_ptr_d - rd_ptr_d) == PW'(DEPTH);
    empty_d = (cmt_ptr_d == rd_ptr_d);
    count_d = cmt_ptr_d - rd_ptr_d;
  end

  // Output and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_port_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_port_q  <= wr_port_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Status and pop data.
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.ovf      = ovf_q;
  assign bus.unf      = unf_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

  // dp_ram port 0: write only.
  assign bus.ram_addr_0 = wr_port_q.addr;
  assign bus.ram_data_0 = wr_port_q.data;
  assign bus.ram_cs_0   = wr_port_q.cs;
  assign bus.ram_we_0   = wr_port_q.we;
  assign bus.ram_oe_0   = 1'b0;

  // dp_ram port 1: read only, head word presented whenever data is committed.
  assign bus.ram_addr_1 = rd_ptr_q[AW-1:0];
  assign bus.ram_cs_1   = !empty_q;
  assign bus.ram_oe_1   = !empty_q;
  assign bus.ram_we_1   = 1'b0;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl with a behavioural dp_ram model.
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fifo_ctrl_if bus ();

  fifo_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // dp_ram: synchronous write on port 0, combinational read on port 1.
  logic [15:0] mem [16];
  always @(posedge clk) begin
    if (bus.ram_cs_0 && bus.ram_we_0) mem[bus.ram_addr_0] <= bus.ram_data_0;
  end
  assign bus.ram_data_1 = mem[bus.ram_addr_1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        flush;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        rd_en;
    logic        e_full;
    logic        e_empty;
    logic [4:0]  e_count;
    logic        e_rv;
    logic [15:0] e_rdata;
    logic        e_ovf;
    logic        e_unf;
    logic        e_we0;
    logic [3:0]  e_addr0;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic fl, input logic we, input logic [15:0] wd, input logic re,
                     input logic fu, input logic em, input logic [4:0] cn, input logic rv,
                     input logic [15:0] rd, input logic ov, input logic un, input logic w0,
                     input logic [3:0] a0);
    vec_t v;
    v.flush = fl; v.wr_en = we; v.wr_data = wd; v.rd_en = re;
    v.e_full = fu; v.e_empty = em; v.e_count = cn; v.e_rv = rv; v.e_rdata = rd;
    v.e_ovf = ov; v.e_unf = un; v.e_we0 = w0; v.e_addr0 = a0;
    vecs.push_back(v);
  endtask

  // Reference model for multi-cycle sequences: committed count, pending write, data queue.
  int          m_cnt  = 0;
  bit          m_pend = 1'b0;
  logic [15:0] mq[$];
  logic [15:0] m_rd;

  task automatic step_model(input logic w, input logic [15:0] wd, input logic r, input string tag);
    bit push_ok;
    bit pop_ok;
    push_ok = w && ((m_cnt + int'(m_pend)) < 16);
    pop_ok  = r && (m_cnt > 0);
    bus.wr_en = w; bus.wr_data = wd; bus.rd_en = r;
    @(posedge clk); #1;
    if (pop_ok) m_rd = mq.pop_front();
    m_cnt  = m_cnt + int'(m_pend) - int'(pop_ok);
    m_pend = push_ok;
    if (push_ok) mq.push_back(wd);
    chk({tag, ".count"}, 32'(bus.count), 32'(m_cnt));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(m_cnt == 0));
    chk({tag, ".full"},  32'(bus.full),  32'((m_cnt + int'(m_pend)) == 16));
    chk({tag, ".rv"},    32'(bus.rd_valid), 32'(pop_ok));
    if (pop_ok) chk({tag, ".rdata"}, 32'(bus.rd_data), 32'(m_rd));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush = 1'b0; bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0;

    // Asynchronous reset values.
    #1 rst_n = 1'b0;
    #1;
    chk("rst.full",   32'(bus.full), 32'd0);
    chk("rst.empty",  32'(bus.empty), 32'd1);
    chk("rst.count",  32'(bus.count), 32'd0);
    chk("rst.rv",     32'(bus.rd_valid), 32'd0);
    chk("rst.rdata",  32'(bus.rd_data), 32'd0);
    chk("rst.ovf",    32'(bus.ovf), 32'd0);
    chk("rst.unf",    32'(bus.unf), 32'd0);
    chk("rst.we0",    32'(bus.ram_we_0), 32'd0);
    chk("rst.cs0",    32'(bus.ram_cs_0), 32'd0);
    chk("rst.addr1",  32'(bus.ram_addr_1), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // flush wr re | full empty cnt rv rdata ovf unf we0 addr0
    add(0, 0, 16'h0000, 1,  0, 1, 5'd0, 0, 16'h0000, 0, 1, 0, 4'd0);   // pop on empty
    add(1, 0, 16'h0000, 0,  0, 1, 5'd0, 0, 16'h0000, 0, 0, 0, 4'd0);   // flush clears unf
    add(0, 1, 16'hA5A5, 0,  0, 1, 5'd0, 0, 16'h0000, 0, 0, 1, 4'd0);   // push: strobe, not yet committed
    add(0, 0, 16'h0000, 0,  0, 0, 5'd1, 0, 16'h0000, 0, 0, 0, 4'd0);   // commit lands
    add(0, 0, 16'h0000, 1,  0, 1, 5'd0, 1, 16'hA5A5, 0, 0, 0, 4'd0);   // pop
    add(0, 0, 16'h0000, 0,  0, 1, 5'd0, 0, 16'hA5A5, 0, 0, 0, 4'd0);   // rd_valid one cycle, data holds
    add(1, 0, 16'h0000, 0,  0, 1, 5'd0, 0, 16'hA5A5, 0, 0, 0, 4'd0);
    for (int i = 0; i < 16; i++)
      add(0, 1, 16'(i), 0, i == 15, i == 0, 5'(i), 0, 16'hA5A5, 0, 0, 1, 4'(i));
    add(0, 1, 16'hDEAD, 0,  1, 0, 5'd16, 0, 16'hA5A5, 1, 0, 0, 4'd15); // push while full
    for (int j = 0; j < 16; j++)
      add(0, 0, 16'h0000, 1, 0, j == 15, 5'(15 - j), 1, 16'(j), 1, 0, 0, 4'd15);
    add(1, 0, 16'h0000, 0,  0, 1, 5'd0, 0, 16'h000F, 0, 0, 0, 4'd15);
    for (int i = 0; i < 16; i++)
      add(0, 1, 16'(32'h100 + i), 0, i == 15, i == 0, 5'(i), 0, 16'h000F, 0, 0, 1, 4'(i));
    add(0, 0, 16'h0000, 0,  1, 0, 5'd16, 0, 16'h000F, 0, 0, 0, 4'd15);
    add(0, 1, 16'hBEEF, 1,  0, 0, 5'd15, 1, 16'h0100, 1, 0, 0, 4'd15); // both at full
    add(1, 0, 16'h0000, 0,  0, 1, 5'd0, 0, 16'h0100, 0, 0, 0, 4'd15);
    add(0, 1, 16'h0077, 1,  0, 1, 5'd0, 0, 16'h0100, 0, 1, 1, 4'd0);   // both at empty
    add(0, 0, 16'h0000, 0,  0, 0, 5'd1, 0, 16'h0100, 0, 1, 0, 4'd0);
    add(0, 0, 16'h0000, 1,  0, 1, 5'd0, 1, 16'h0077, 0, 1, 0, 4'd0);
    add(1, 1, 16'hFFFF, 1,  0, 1, 5'd0, 0, 16'h0077, 0, 0, 0, 4'd0);   // flush beats push/pop

    for (int i = 0; i < vecs.size(); i++) begin
      bus.flush = vecs[i].flush; bus.wr_en = vecs[i].wr_en;
      bus.wr_data = vecs[i].wr_data; bus.rd_en = vecs[i].rd_en;
      @(posedge clk); #1;
      chk($sformatf("v%0d.full", i),  32'(bus.full),       32'(vecs[i].e_full));
      chk($sformatf("v%0d.empty", i), 32'(bus.empty),      32'(vecs[i].e_empty));
      chk($sformatf("v%0d.count", i), 32'(bus.count),      32'(vecs[i].e_count));
      chk($sformatf("v%0d.rv", i),    32'(bus.rd_valid),   32'(vecs[i].e_rv));
      chk($sformatf("v%0d.rdata", i), 32'(bus.rd_data),    32'(vecs[i].e_rdata));
      chk($sformatf("v%0d.ovf", i),   32'(bus.ovf),        32'(vecs[i].e_ovf));
      chk($sformatf("v%0d.unf", i),   32'(bus.unf),        32'(vecs[i].e_unf));
      chk($sformatf("v%0d.we0", i),   32'(bus.ram_we_0),   32'(vecs[i].e_we0));
      chk($sformatf("v%0d.cs0", i),   32'(bus.ram_cs_0),   32'(vecs[i].e_we0));
      chk($sformatf("v%0d.addr0", i), 32'(bus.ram_addr_0), 32'(vecs[i].e_addr0));
      chk($sformatf("v%0d.cs1", i),   32'(bus.ram_cs_1),   32'(!vecs[i].e_empty));
    end
    bus.flush = 1'b0;

    // Wrap-around: prefill 4, then mixed push/pop across address 15 -> 0.
    for (int k = 0; k < 4; k++) step_model(1'b1, 16'(32'h3000 + k), 1'b0, $sformatf("pre%0d", k));
    step_model(1'b0, 16'h0000, 1'b0, "pre_idle");
    for (int i = 0; i < 20; i++) begin
      logic w;
      logic r;
      w = (i % 4) != 2;
      r = (i % 4) != 0;
      step_model(w, 16'(32'h3100 + i), r, $sformatf("wrap%0d", i));
    end

    // Reset in the middle of a write burst.
    step_model(1'b1, 16'h4001, 1'b0, "burst0");
    step_model(1'b1, 16'h4002, 1'b0, "burst1");
    chk("burst.we0", 32'(bus.ram_we_0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.we0",   32'(bus.ram_we_0), 32'd0);
    chk("mid.cs0",   32'(bus.ram_cs_0), 32'd0);
    chk("mid.empty", 32'(bus.empty), 32'd1);
    chk("mid.count", 32'(bus.count), 32'd0);
    chk("mid.full",  32'(bus.full), 32'd0);
    chk("mid.rv",    32'(bus.rd_valid), 32'd0);
    chk("mid.rdata", 32'(bus.rd_data), 32'd0);
    chk("mid.addr1", 32'(bus.ram_addr_1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.wr_en = 1'b1; bus.wr_data = 16'h1234; bus.rd_en = 1'b0;
    @(posedge clk); #1;
    chk("post.we0",   32'(bus.ram_we_0), 32'd1);
    chk("post.addr0", 32'(bus.ram_addr_0), 32'd0);
    bus.wr_en = 1'b0;
    @(posedge clk); #1;
    chk("post.count", 32'(bus.count), 32'd1);
    chk("post.addr1", 32'(bus.ram_addr_1), 32'd0);
    bus.rd_en = 1'b1;
    @(posedge clk); #1;
    chk("post.rdata", 32'(bus.rd_data), 32'h1234);
    chk("post.rv",    32'(bus.rd_valid), 32'd1);
    chk("post.empty", 32'(bus.empty), 32'd1);
    bus.rd_en = 1'b0;
    @(posedge clk); #1;
    chk("post.rv_drop", 32'(bus.rd_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
